// File: rtl/next_pc_unit.sv
// rtl/next_pc_unit.sv - fetch PC register with direct-mapped BTB prediction and execute-stage redirect
module next_pc_unit #(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_PC    = '0,
  parameter int              BTB_ENTRIES = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  output logic [XLEN-1:0] pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_npc,
  input  logic            ex_valid,
  input  logic            ex_is_ctrl,
  input  logic            ex_is_jalr,
  input  logic            ex_br_taken,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_imm,
  input  logic [XLEN-1:0] ex_reg1dat,
  input  logic [XLEN-1:0] ex_pred_npc,
  output logic            flush,
  output logic [31:0]     mispredict_cnt
);

  localparam int IDX  = $clog2(BTB_ENTRIES);
  localparam int TAGW = XLEN - IDX - 2;

  logic [XLEN-1:0]        pc_q, pc_d;
  logic [31:0]            cnt_q, cnt_d;
  logic [BTB_ENTRIES-1:0] valid_q, valid_d;
  logic [TAGW-1:0]        tag_q    [BTB_ENTRIES];
  logic [TAGW-1:0]        tag_d    [BTB_ENTRIES];
  logic [XLEN-1:0]        target_q [BTB_ENTRIES];
  logic [XLEN-1:0]        target_d [BTB_ENTRIES];
  logic [1:0]             ctr_q    [BTB_ENTRIES];
  logic [1:0]             ctr_d    [BTB_ENTRIES];

  logic [IDX-1:0]  rd_idx, wr_idx;
  logic [TAGW-1:0] rd_tag, wr_tag;
  logic            rd_hit, wr_hit;
  logic [XLEN-1:0] jalr_sum, actual;

  // Prediction reads the registered BTB, so a same-cycle update is not visible yet.
  assign rd_idx     = pc_q[IDX+1:2];
  assign rd_tag     = pc_q[XLEN-1:IDX+2];
  assign rd_hit     = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign pred_taken = rd_hit && ctr_q[rd_idx][1];
  assign pred_npc   = pred_taken ? target_q[rd_idx] : pc_q + XLEN'(4);
  assign pc         = pc_q;

  assign wr_idx   = ex_pc[IDX+1:2];
  assign wr_tag   = ex_pc[XLEN-1:IDX+2];
  assign wr_hit   = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);
  assign jalr_sum = ex_reg1dat + ex_imm;

  always_comb begin
    actual = ex_pc + XLEN'(4);
    if (ex_is_jalr)       actual = {jalr_sum[XLEN-1:1], 1'b0};
    else if (ex_br_taken) actual = ex_pc + ex_imm;
  end

  assign flush          = rst_n && ex_valid && (actual != ex_pred_npc);
  assign mispredict_cnt = cnt_q;

  always_comb begin
    pc_d = pc_q;
    if (flush)       pc_d = actual;
    else if (!stall) pc_d = pred_npc;
    cnt_d = cnt_q;
    if (flush && (cnt_q != 32'hFFFF_FFFF)) cnt_d = cnt_q + 32'd1;
  end

  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    if (ex_valid && ex_is_ctrl) begin
      if (wr_hit) begin
        if (ex_br_taken) begin
          target_d[wr_idx] = actual;
          if (ctr_q[wr_idx] != 2'b11) ctr_d[wr_idx] = ctr_q[wr_idx] + 2'd1;
        end else if (ctr_q[wr_idx] != 2'b00) begin
          ctr_d[wr_idx] = ctr_q[wr_idx] - 2'd1;
        end
      end else if (ex_br_taken) begin
        valid_d[wr_idx]  = 1'b1;
        tag_d[wr_idx]    = wr_tag;
        target_d[wr_idx] = actual;
        ctr_d[wr_idx]    = 2'b10;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
      valid_q <= '0;
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
    end else begin
      pc_q     <= pc_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      target_q <= target_d;
      ctr_q    <= ctr_d;
    end
  end

endmodule
